// File: rtl/cam_pixel_assembler_if.sv
// Pixel-assembler bus: camera byte stream in, assembled pixel stream out.
// Strobe semantics: i_byte_valid marks exactly one camera byte per high cycle
// and there is no backpressure. o_valid marks exactly one pixel per high cycle
// and the consumer must take it in that cycle. o_data is stable whenever
// o_valid is low.
interface cam_pixel_assembler_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  i_enable;
  logic                  i_byte_valid;
  logic                  i_vsync;
  logic                  i_href;
  logic [7:0]            i_data;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_flush;
  logic                  o_frame_done;
  logic                  o_frame_err;
  logic                  o_busy;
  logic [1:0]            o_dbg_state;

  // Driver side: the camera front-end or the testbench.
  modport master (
    output i_enable, i_byte_valid, i_vsync, i_href, i_data,
    input  o_valid, o_data, o_flush, o_frame_done, o_frame_err, o_busy,
           o_dbg_state
  );

  // Assembler side.
  modport slave (
    input  i_enable, i_byte_valid, i_vsync, i_href, i_data,
    output o_valid, o_data, o_flush, o_frame_done, o_frame_err, o_busy,
           o_dbg_state
  );
endinterface

// File: rtl/cam_pixel_assembler.sv
// Camera capture front-end. Pairs "xR GB" bytes into RGB444 pixels, gates
// capture to whole frames, and flags frames whose geometry does not match
// H_ACTIVE x V_ACTIVE.
module cam_pixel_assembler #(
  parameter int DATA_WIDTH = 12,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input logic                  i_clk,
  input logic                  i_rst,
  cam_pixel_assembler_if.slave bus
);

  localparam int PW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);
  localparam logic [PW-1:0] H_MAX = PW'(H_ACTIVE);
  localparam logic [LW-1:0] V_MAX = LW'(V_ACTIVE);

  typedef enum logic [1:0] {
    S_SYNC       = 2'd0,
    S_WAIT_START = 2'd1,
    S_ACTIVE     = 2'd2
  } state_t;

  state_t        state;
  logic          vsync_q;
  logic          href_q;
  logic          phase;
  logic [3:0]    red_q;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;

  logic          byte_acc;
  logic          vsync_fall;
  logic          vsync_rise;
  logic          href_fall;
  logic          pix_in_range;
  logic          pix_err;
  logic          line_err;
  logic          err_now;
  logic [LW-1:0] line_cnt_upd;

  assign bus.o_dbg_state = state;

  // Edge detection, line-end bookkeeping and the error term for this cycle.
  // line_cnt_upd lets the frame-end check see a line that ends in the same
  // cycle as VSYNC rises.
  always_comb begin
    byte_acc     = bus.i_byte_valid & bus.i_href;
    vsync_fall   = vsync_q & ~bus.i_vsync;
    vsync_rise   = ~vsync_q & bus.i_vsync;
    href_fall    = href_q & ~bus.i_href;
    pix_in_range = (pix_cnt < H_MAX) && (line_cnt < V_MAX);
    pix_err      = byte_acc & phase & ~pix_in_range;
    line_err     = href_fall & (phase | (pix_cnt != H_MAX));
    line_cnt_upd = line_cnt;
    if (href_fall && (line_cnt != V_MAX)) begin
      line_cnt_upd = line_cnt + LW'(1);
    end
    err_now = bus.o_frame_err | pix_err | line_err;
  end

  // Frame FSM, byte pairing, counters and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= S_SYNC;
      vsync_q          <= bus.i_vsync;
      href_q           <= bus.i_href;
      phase            <= 1'b0;
      red_q            <= 4'd0;
      pix_cnt          <= '0;
      line_cnt         <= '0;
      bus.o_valid      <= 1'b0;
      bus.o_data       <= '0;
      bus.o_flush      <= 1'b0;
      bus.o_frame_done <= 1'b0;
      bus.o_frame_err  <= 1'b0;
      bus.o_busy       <= 1'b0;
    end else begin
      vsync_q          <= bus.i_vsync;
      href_q           <= bus.i_href;
      bus.o_valid      <= 1'b0;
      bus.o_flush      <= 1'b0;
      bus.o_frame_done <= 1'b0;
      case (state)
        S_SYNC: begin
          if (bus.i_vsync) begin
            state <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (vsync_fall) begin
            if (bus.i_enable) begin
              state           <= S_ACTIVE;
              bus.o_busy      <= 1'b1;
              line_cnt        <= '0;
              pix_cnt         <= '0;
              phase           <= 1'b0;
              bus.o_frame_err <= 1'b0;
              bus.o_flush     <= 1'b1;
            end else begin
              state <= S_SYNC;
            end
          end
        end
        S_ACTIVE: begin
          if (byte_acc) begin
            if (!phase) begin
              red_q <= bus.i_data[3:0];
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (pix_in_range) begin
                bus.o_valid <= 1'b1;
                bus.o_data  <= DATA_WIDTH'({red_q, bus.i_data});
              end
              if (pix_cnt != H_MAX) begin
                pix_cnt <= pix_cnt + PW'(1);
              end
            end
          end
          if (href_fall) begin
            pix_cnt  <= '0;
            phase    <= 1'b0;
            line_cnt <= line_cnt_upd;
          end
          bus.o_frame_err <= err_now;
          if (vsync_rise) begin
            if ((line_cnt_upd == V_MAX) && !err_now) begin
              bus.o_frame_done <= 1'b1;
            end else begin
              bus.o_frame_err <= 1'b1;
              bus.o_flush     <= 1'b1;
            end
            state      <= S_WAIT_START;
            bus.o_busy <= 1'b0;
          end
        end
        default: begin
          state      <= S_SYNC;
          bus.o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cam_pixel_assembler.md
Name: cam_pixel_assembler

Overview:
- Capture front-end that feeds the frame-buffer write stage.
- Input: OV7670-style byte stream (RGB444, "xR GB" byte order) with VSYNC/HREF, already synchronised into the system clock domain, one strobe per camera byte.
- Assembles byte pairs into 12-bit pixels, gates capture to whole frames, and drives the downstream pixel valid/data and flush inputs.
- Reports frame completion and geometry errors.

Parameters:
- DATA_WIDTH, 12, output pixel width (RGB444; fixed at 12, other values unsupported)
- H_ACTIVE, 640, pixels per active line
- V_ACTIVE, 480, active lines per frame

Ports:
- i_clk  input  1  system clock (125 MHz)
- i_rst  input  1  synchronous active-high reset
- i_enable  input  1  capture enable, sampled only at frame start
- i_byte_valid  input  1  one-cycle strobe per camera byte
- i_vsync  input  1  frame sync, active high between frames
- i_href  input  1  line valid, high during active bytes
- i_data  input  8  camera byte
- o_valid  output  1  pixel valid (one cycle per pixel)
- o_data  output  DATA_WIDTH  pixel {R[3:0],G[3:0],B[3:0]}
- o_flush  output  1  one-cycle pulse; resets downstream write address
- o_frame_done  output  1  one-cycle pulse after a complete, error-free frame
- o_frame_err  output  1  sticky error flag; cleared at next accepted frame start
- o_busy  output  1  high while in ACTIVE

Behaviour:
- Reset: i_clk and i_rst only; i_rst is synchronous, active-high.
  - All outputs are 0 and o_data is 0.
  - State = SYNC; counters and phase are cleared.
  - The VSYNC/HREF edge registers load the current inputs, so no spurious edge is seen on release.
- Edge detection: registered copies of i_vsync and i_href, evaluated every i_clk cycle (not gated by i_byte_valid).
- States:
  - SYNC: wait for i_vsync = 1, then go to WAIT_START. A frame already in progress after reset is discarded.
  - WAIT_START: on the i_vsync falling edge:
    - If i_enable = 1: go to ACTIVE; clear line_cnt, pix_cnt and phase; clear o_frame_err; pulse o_flush for one cycle.
    - Otherwise go to SYNC.
  - ACTIVE: a byte is accepted when i_byte_valid & i_href.
    - phase 0: latch R = i_data[3:0]; phase <= 1.
    - phase 1: form {R, i_data[7:4], i_data[3:0]}. If pix_cnt < H_ACTIVE and line_cnt < V_ACTIVE, o_valid = 1 and o_data is updated on the next cycle (latency 1 cycle from the second byte strobe). pix_cnt increments, saturating at H_ACTIVE; phase <= 0.
    - Surplus pixels or lines beyond the geometry are dropped and set o_frame_err.
- o_data holds its last value when o_valid = 0.
- HREF falling edge (end of line) in ACTIVE:
  - If phase = 1: the partial byte is dropped and o_frame_err is set.
  - If pix_cnt != H_ACTIVE: o_frame_err is set.
  - pix_cnt <= 0, phase <= 0, line_cnt increments, saturating at V_ACTIVE.
- i_vsync rising edge in ACTIVE (end of frame):
  - If line_cnt == V_ACTIVE and no error, pulse o_frame_done.
  - Otherwise set o_frame_err and pulse o_flush so the downstream stage drops the partial frame.
  - Go to WAIT_START.
- Simultaneous HREF fall and VSYNC rise: the line-end processing applies first, then the frame-end check uses the updated line_cnt.
- i_enable deasserted mid-frame: the current frame completes normally; no new frame starts.
- Reset mid-frame: o_valid drops immediately on the next cycle; capture resumes only after a full VSYNC high→low sequence.
- Counter widths: pix_cnt is $clog2(H_ACTIVE+1) bits; line_cnt is $clog2(V_ACTIVE+1) bits.

Test Plan:
- Nominal frame, 640x480 with H_ACTIVE/V_ACTIVE defaults: exactly 307200 o_valid pulses, one o_flush at frame start, one o_frame_done, o_frame_err = 0.
- Byte pair 0x0A then 0x5C: o_data = 0xA5C, o_valid high exactly one cycle after the second strobe.
- Line with 1281 bytes (odd count): 640 pixels out, trailing byte dropped, o_frame_err = 1, no o_frame_done at VSYNC rise, o_flush pulses.
- Line with 650 pixels: only 640 o_valid pulses; o_frame_err = 1.
- Reset asserted mid-frame at pixel 1000: no o_valid until the next VSYNC falls. Then the next full frame yields o_flush, 307200 pixels and o_frame_done, with o_frame_err cleared.
- i_enable = 0 at VSYNC fall: zero o_valid and no o_flush for that frame. i_enable set back to 1 before the next VSYNC fall: capture resumes.
